tlul_periph_reg_adapter: RTL and testbench
==========================================

Name: tlul_periph_reg_adapter

Overview:
- Device-side TL-UL endpoint placed directly downstream of the peripheral crossbar's m1 socket outputs (LDO, DCDC, PLL, TSEN, GPIO, ...).
- Converts one TL-UL A-channel request at a time into a single-word register access (req/we/addr/wdata/be) toward the peripheral register file.
- Waits for the register side to complete, which may take several cycles for analog-clocked registers, then returns the D-channel response.
- Performs protocol legality checks; illegal requests never reach the register side and receive an error response.

Parameters:
- RegAw, 8, register-space byte-address width; a_address bits above RegAw-1 must be zero.
- TimeoutCycles, 16, register-side wait limit in cycles (used only with the optional feature; legal range 2..255).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- tl_i  input  tlul_pkg::tl_h2d_t  TL-UL request from crossbar
- tl_o  output  tlul_pkg::tl_d2h_t  TL-UL response to crossbar
- reg_req_o  output  1  register access strobe, held until reg_ready_i
- reg_we_o  output  1  1=write, 0=read
- reg_addr_o  output  RegAw  word-aligned byte address (bits [1:0]=0)
- reg_wdata_o  output  32  write data
- reg_be_o  output  4  byte enables (= a_mask)
- reg_rdata_i  input  32  read data, valid when reg_ready_i=1
- reg_ready_i  input  1  access complete this cycle
- reg_error_i  input  1  peripheral error, sampled with reg_ready_i

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (rst_i=1 at a clk_i edge) forces IDLE; all outputs 0 except a_ready.
- IDLE: a_ready=1. On a_valid, capture a_opcode, a_size, a_source, a_address, a_mask and a_data. If legal, go to ACCESS; if illegal, go to RESP with err=1.
- ACCESS: a_ready=0. reg_req_o=1 with reg_* driven from the captured registers, stable throughout the state.
  - On reg_ready_i: latch rdata (reads only) and err=reg_error_i; go to RESP.
- RESP: d_valid=1. All d_* fields are registered and stable until d_ready.
  - d_opcode = AccessAckData(1) for Get, else AccessAck(0).
  - d_size and d_source are echoed from the request; d_param=0; d_sink=0.
  - d_error=err.
  - d_data = rdata on a good read; 32'hFFFF_FFFF on an errored read; 0 for writes.
  - On d_ready: go to IDLE. a_ready rises the following cycle, so there is no back-to-back acceptance and a maximum of one outstanding transaction.
- Minimum latency, request accepted at edge N with reg_ready_i=1 on the first ACCESS cycle:
  - reg_req_o high in cycle N+1.
  - d_valid high in cycle N+2.
  - Illegal requests: d_valid high in cycle N+1.
- Legality; any failure gives err=1 and no register access:
  - opcode is Get(4), PutFullData(0) or PutPartialData(1).
  - a_size <= 2.
  - address aligned to a_size.
  - a_address[31:RegAw]==0.
  - a_mask nonzero and confined to the bytes selected by size/address.
  - PutFullData mask exactly equals the size-implied mask.
- Get forces reg_be_o=4'hF regardless of a_mask.
- reg_ready_i outside ACCESS is ignored. reg_error_i is ignored unless reg_ready_i=1.
- Reset asserted mid-ACCESS or mid-RESP:
  - reg_req_o and d_valid drop the cycle after the reset edge.
  - The pending transaction is dropped with no response.

Optional Feature:
- Macro TLUL_PERIPH_REG_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without reg_ready_i.
  - When it reaches TimeoutCycles-1 without ready, reg_req_o drops and the FSM enters RESP with d_error=1 (and d_data=FFFF_FFFF on reads).
  - A late reg_ready_i arriving after the timeout is ignored.
- Undefined: no counter exists; ACCESS waits indefinitely.

Decomposition:
- tlul_pkg (existing) supplies tl_h2d_t/tl_d2h_t and the opcode enums.
- Add to the new package periph_reg_pkg:
  - state enum (IDLE/ACCESS/RESP)
  - constant ERR_RDATA=32'hFFFF_FFFF
  - function mask_for(size, addr[1:0])
- One sub-module is natural: tlul_req_check, a purely combinational legality checker emitting a single err bit. It stays reusable by other endpoints.

Test Plan:
- Get addr 0x10, size 2, reg_ready_i same cycle, rdata 0xDEADBEEF -> d_valid at N+2, opcode 1, d_data 0xDEADBEEF, d_error 0, d_source echoed.
- PutPartialData addr 0x06, size 1, mask 4'b1100, data 0xABCD0000, reg_ready_i after 3 wait cycles -> reg_be_o 4'b1100, reg_addr_o 0x04, reg_we_o=1 held 4 cycles, AccessAck with d_error 0.
- Illegal requests: PutFullData size 2 mask 4'b0011, Get addr 0x02 size 2, and Get addr 0x100 with RegAw=8 -> reg_req_o never asserts, d_valid at N+1, d_error 1, Get data 0xFFFF_FFFF.
- d_ready held 0 for 5 cycles in RESP -> d_* stable, a_ready 0 throughout; new a_valid accepted only the cycle after the d_ready handshake.
- reg_error_i=1 with reg_ready_i on a write -> AccessAck with d_error 1; rst_i pulsed during ACCESS -> reg_req_o 0 next cycle, no response, a_ready 1.
- With TLUL_PERIPH_REG_TIMEOUT_EN and TimeoutCycles=16, reg_ready_i never asserted -> reg_req_o high 16 cycles, then d_error 1; a reg_ready_i pulse one cycle later has no effect.

Source files
------------

// File: rtl/periph_reg_pkg.sv
// Shared types and helpers for the TL-UL peripheral register adapter.
// Holds the FSM state enum, error read data and the lane-mask helper.
package periph_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  // Byte lanes covered by an access of 2**size bytes at addr[1:0].
  function automatic logic [3:0] mask_for(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] m;
    unique case (size)
      2'd0:    m = 4'b0001 << addr;
      2'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL request/response bundles and opcode enums shared across the crossbar.
// Reduced to the fields used by the single-word peripheral endpoints.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_req_check.sv
// Combinational TL-UL A-channel legality check for single-word endpoints.
// Ports: opcode/size/address/mask in; err=1 when the request is illegal.
module tlul_req_check
  import tlul_pkg::*;
  import periph_reg_pkg::*;
#(
  parameter int unsigned RegAw = 8
) (
  input  tl_a_op_e    opcode,
  input  logic [1:0]  size,
  input  logic [31:0] address,
  input  logic [3:0]  mask,
  output logic        err
);

  logic       op_ok;
  logic       size_ok;
  logic       align_ok;
  logic       addr_ok;
  logic       mask_ok;
  logic       full_ok;
  logic [3:0] lanes;

  assign lanes   = mask_for(size, address[1:0]);
  assign op_ok   = opcode inside {Get, PutFullData, PutPartialData};
  assign size_ok = size <= 2'd2;
  assign addr_ok = (address >> RegAw) == 32'h0;
  assign mask_ok = (mask != 4'h0) && ((mask & ~lanes) == 4'h0);
  assign full_ok = (opcode != PutFullData) || (mask == lanes);

  always_comb begin
    align_ok = 1'b0;
    unique case (size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~address[0];
      default: align_ok = address[1:0] == 2'b00;
    endcase
  end

  assign err = ~(op_ok & size_ok & align_ok & addr_ok & mask_ok & full_ok);

endmodule

// File: rtl/tlul_periph_reg_adapter.sv
// TL-UL device endpoint turning one A request into one register access.
// Ports: clk_i/rst_i (sync, active-high), tl_i/tl_o TL-UL, reg_* register side.
// Optional TLUL_PERIPH_REG_TIMEOUT_EN: abort ACCESS after TimeoutCycles.
module tlul_periph_reg_adapter
  import tlul_pkg::*;
  import periph_reg_pkg::*;
#(
  parameter int unsigned RegAw         = 8,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  tl_h2d_t          tl_i,
  output tl_d2h_t          tl_o,
  output logic             reg_req_o,
  output logic             reg_we_o,
  output logic [RegAw-1:0] reg_addr_o,
  output logic [31:0]      reg_wdata_o,
  output logic [3:0]       reg_be_o,
  input  logic [31:0]      reg_rdata_i,
  input  logic             reg_ready_i,
  input  logic             reg_error_i
);

  if (TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_tmo_range
    $error("TimeoutCycles must be in 2..255");
  end

  state_e           state_q;
  state_e           state_d;
  tl_a_op_e         op_q;
  logic [1:0]       size_q;
  logic [7:0]       source_q;
  logic [RegAw-1:2] addr_q;
  logic [3:0]       mask_q;
  logic [31:0]      data_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             chk_err;
  logic             accept;
  logic             in_access;
  logic             in_resp;
  logic             done;
  logic             is_get;
  logic             tmo_hit;

  tlul_req_check #(
    .RegAw(RegAw)
  ) u_check (
    .opcode (tl_i.a_opcode),
    .size   (tl_i.a_size),
    .address(tl_i.a_address),
    .mask   (tl_i.a_mask),
    .err    (chk_err)
  );

  assign in_access = state_q == ACCESS;
  assign in_resp   = state_q == RESP;
  assign accept    = (state_q == IDLE) & tl_i.a_valid;
  assign done      = in_access & reg_ready_i;
  assign is_get    = op_q == Get;

`ifdef TLUL_PERIPH_REG_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TimeoutCycles - 1);

  logic [7:0] tmo_cnt_q;

  assign tmo_hit = in_access & ~reg_ready_i & (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= 8'h0;
    end else if (accept) begin
      tmo_cnt_q <= 8'h0;
    end else if (in_access && !reg_ready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 8'h1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tl_i.a_valid) state_d = chk_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (reg_ready_i || tmo_hit) state_d = RESP;
      end
      RESP: begin
        if (tl_i.d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= PutFullData;
      size_q   <= 2'd0;
      source_q <= 8'h0;
      addr_q   <= '0;
      mask_q   <= 4'h0;
      data_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q     <= tl_i.a_opcode;
      size_q   <= tl_i.a_size;
      source_q <= tl_i.a_source;
      addr_q   <= tl_i.a_address[RegAw-1:2];
      mask_q   <= tl_i.a_mask;
      data_q   <= tl_i.a_data;
      err_q    <= chk_err;
    end else if (done) begin
      err_q <= reg_error_i;
      if (is_get) rdata_q <= reg_rdata_i;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign reg_req_o   = in_access;
  assign reg_we_o    = in_access & ~is_get;
  assign reg_addr_o  = in_access ? {addr_q, 2'b00} : '0;
  assign reg_wdata_o = in_access ? data_q : 32'h0;
  assign reg_be_o    = !in_access ? 4'h0 :
                       is_get     ? 4'hF : mask_q;

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = state_q == IDLE;
    if (in_resp) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = is_get ? AccessAckData : AccessAck;
      tl_o.d_size   = size_q;
      tl_o.d_source = source_q;
      tl_o.d_error  = err_q;
      tl_o.d_data   = !is_get ? 32'h0 :
                      err_q   ? ERR_RDATA : rdata_q;
    end
  end

endmodule

// File: tb/tb_tlul_periph_reg_adapter.sv
// Directed self-checking bench for tlul_periph_reg_adapter.
// One task per scenario; expected values are hand-computed constants.
module tb_tlul_periph_reg_adapter;
  import tlul_pkg::*;

  logic        clk;
  logic        rst;
  tl_h2d_t     h;
  tl_d2h_t     d;
  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        reg_error;

  int total = 0;
  int bad   = 0;

  tlul_periph_reg_adapter #(
    .RegAw(8),
    .TimeoutCycles(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tl_i       (h),
    .tl_o       (d),
    .reg_req_o  (reg_req),
    .reg_we_o   (reg_we),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_be_o   (reg_be),
    .reg_rdata_i(reg_rdata),
    .reg_ready_i(reg_ready),
    .reg_error_i(reg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] size,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src);
    h.a_valid   = 1'b1;
    h.a_opcode  = tl_a_op_e'(op);
    h.a_size    = size;
    h.a_address = addr;
    h.a_mask    = mask;
    h.a_data    = data;
    h.a_source  = src;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (d.a_ready !== 1'b1) begin
      bad++; $display("FAIL reset_a_ready: got %b want 1", d.a_ready);
    end
    total++;
    if (d.d_valid !== 1'b0 || reg_req !== 1'b0 || reg_we !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got dv=%b req=%b we=%b want 0", d.d_valid, reg_req, reg_we);
    end
    total++;
    if (reg_addr !== 8'h0 || reg_be !== 4'h0 || reg_wdata !== 32'h0 || d.d_data !== 32'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h be=%h wd=%h dd=%h want 0", reg_addr, reg_be, reg_wdata, d.d_data);
    end
  endtask

  task automatic test_get();
    drive_a(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'h05);
    reg_ready = 1'b1;
    reg_rdata = 32'hDEAD_BEEF;
    total++;
    if (d.a_ready !== 1'b1) begin
      bad++; $display("FAIL get_a_ready: got %b want 1", d.a_ready);
    end
    tick();
    h.a_valid = 1'b0;
    total++;
    if (reg_req !== 1'b1 || reg_we !== 1'b0 || reg_addr !== 8'h10 || reg_be !== 4'hF || d.d_valid !== 1'b0) begin
      bad++; $display("FAIL get_access: got req=%b we=%b addr=%h be=%h dv=%b want 1 0 10 f 0", reg_req, reg_we, reg_addr, reg_be, d.d_valid);
    end
    tick();
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b1 || d.d_opcode !== AccessAckData || d.d_data !== 32'hDEAD_BEEF || d.d_error !== 1'b0) begin
      bad++; $display("FAIL get_resp: got dv=%b op=%0d data=%h err=%b want 1 1 deadbeef 0", d.d_valid, d.d_opcode, d.d_data, d.d_error);
    end
    total++;
    if (d.d_source !== 8'h05 || d.d_size !== 2'd2 || reg_req !== 1'b0 || d.a_ready !== 1'b0) begin
      bad++; $display("FAIL get_echo: got src=%h size=%0d req=%b ar=%b want 05 2 0 0", d.d_source, d.d_size, reg_req, d.a_ready);
    end
    tick();
    total++;
    if (d.d_valid !== 1'b0 || d.a_ready !== 1'b1) begin
      bad++; $display("FAIL get_idle: got dv=%b ar=%b want 0 1", d.d_valid, d.a_ready);
    end
  endtask

  task automatic test_get_byte();
    drive_a(3'd4, 2'd0, 32'hF3, 4'b1000, 32'h0, 8'h21);
    reg_ready = 1'b1;
    reg_rdata = 32'h0102_0304;
    tick();
    h.a_valid = 1'b0;
    total++;
    if (reg_req !== 1'b1 || reg_be !== 4'hF || reg_addr !== 8'hF0) begin
      bad++; $display("FAIL get_byte_access: got req=%b be=%h addr=%h want 1 f f0", reg_req, reg_be, reg_addr);
    end
    tick();
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b1 || d.d_error !== 1'b0 || d.d_data !== 32'h0102_0304 || d.d_size !== 2'd0) begin
      bad++; $display("FAIL get_byte_resp: got dv=%b err=%b data=%h size=%0d want 1 0 01020304 0", d.d_valid, d.d_error, d.d_data, d.d_size);
    end
    tick();
  endtask

  task automatic test_put_partial();
    drive_a(3'd1, 2'd1, 32'h06, 4'b1100, 32'hABCD_0000, 8'h33);
    reg_ready = 1'b0;
    reg_error = 1'b1;
    tick();
    h.a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (reg_req !== 1'b1 || reg_we !== 1'b1 || reg_be !== 4'b1100 || reg_addr !== 8'h04 || reg_wdata !== 32'hABCD_0000 || d.d_valid !== 1'b0) begin
        bad++; $display("FAIL put_hold[%0d]: got req=%b we=%b be=%b addr=%h wd=%h dv=%b", i, reg_req, reg_we, reg_be, reg_addr, reg_wdata, d.d_valid);
      end
      if (i == 3) begin
        reg_ready = 1'b1;
        reg_error = 1'b0;
      end
      tick();
    end
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b1 || d.d_opcode !== AccessAck || d.d_error !== 1'b0 || d.d_data !== 32'h0 || d.d_size !== 2'd1 || d.d_source !== 8'h33) begin
      bad++; $display("FAIL put_resp: got dv=%b op=%0d err=%b data=%h size=%0d src=%h want 1 0 0 0 1 33", d.d_valid, d.d_opcode, d.d_error, d.d_data, d.d_size, d.d_source);
    end
    total++;
    if (reg_req !== 1'b0) begin
      bad++; $display("FAIL put_req_drop: got %b want 0", reg_req);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [2:0]  op   [7];
    logic [1:0]  sz   [7];
    logic [31:0] ad   [7];
    logic [3:0]  mk   [7];
    logic [31:0] exp_data;
    op = '{3'd0, 3'd4, 3'd4, 3'd2, 3'd1, 3'd1, 3'd4};
    sz = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd3};
    ad = '{32'h0, 32'h2, 32'h100, 32'h0, 32'h1, 32'h0, 32'h0};
    mk = '{4'b0011, 4'hF, 4'hF, 4'hF, 4'b0100, 4'h0, 4'hF};
    for (int i = 0; i < 7; i++) begin
      drive_a(op[i], sz[i], ad[i], mk[i], 32'h1234_5678, 8'(i));
      reg_ready = 1'b1;
      tick();
      h.a_valid = 1'b0;
      reg_ready = 1'b0;
      exp_data = (op[i] == 3'd4) ? 32'hFFFF_FFFF : 32'h0;
      total++;
      if (reg_req !== 1'b0 || d.d_valid !== 1'b1 || d.d_error !== 1'b1 || d.d_data !== exp_data) begin
        bad++; $display("FAIL illegal[%0d]: got req=%b dv=%b err=%b data=%h want 0 1 1 %h", i, reg_req, d.d_valid, d.d_error, d.d_data, exp_data);
      end
      total++;
      if (d.d_opcode !== ((op[i] == 3'd4) ? AccessAckData : AccessAck) || d.d_source !== 8'(i)) begin
        bad++; $display("FAIL illegal_op[%0d]: got op=%0d src=%h", i, d.d_opcode, d.d_source);
      end
      tick();
      total++;
      if (d.d_valid !== 1'b0 || d.a_ready !== 1'b1 || reg_req !== 1'b0) begin
        bad++; $display("FAIL illegal_idle[%0d]: got dv=%b ar=%b req=%b want 0 1 0", i, d.d_valid, d.a_ready, reg_req);
      end
    end
  endtask

  task automatic test_back_to_back();
    h.d_ready = 1'b0;
    drive_a(3'd4, 2'd2, 32'h24, 4'hF, 32'h0, 8'h09);
    reg_ready = 1'b1;
    reg_rdata = 32'h1234_5678;
    tick();
    drive_a(3'd0, 2'd2, 32'h28, 4'hF, 32'h0000_0055, 8'h0A);
    tick();
    reg_ready = 1'b0;
    reg_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (d.d_valid !== 1'b1 || d.d_data !== 32'h1234_5678 || d.d_source !== 8'h09 || d.a_ready !== 1'b0 || reg_req !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: got dv=%b data=%h src=%h ar=%b req=%b", i, d.d_valid, d.d_data, d.d_source, d.a_ready, reg_req);
      end
      tick();
    end
    h.d_ready = 1'b1;
    tick();
    total++;
    if (d.a_ready !== 1'b1 || d.d_valid !== 1'b0 || reg_req !== 1'b0) begin
      bad++; $display("FAIL bp_after_hs: got ar=%b dv=%b req=%b want 1 0 0", d.a_ready, d.d_valid, reg_req);
    end
    tick();
    h.a_valid = 1'b0;
    total++;
    if (reg_req !== 1'b1 || reg_we !== 1'b1 || reg_addr !== 8'h28 || reg_wdata !== 32'h55) begin
      bad++; $display("FAIL bp_next_access: got req=%b we=%b addr=%h wd=%h want 1 1 28 55", reg_req, reg_we, reg_addr, reg_wdata);
    end
    reg_ready = 1'b1;
    tick();
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b1 || d.d_opcode !== AccessAck || d.d_source !== 8'h0A || d.d_error !== 1'b0) begin
      bad++; $display("FAIL bp_next_resp: got dv=%b op=%0d src=%h err=%b want 1 0 0a 0", d.d_valid, d.d_opcode, d.d_source, d.d_error);
    end
    tick();
  endtask

  task automatic test_reg_error();
    drive_a(3'd0, 2'd2, 32'h20, 4'hF, 32'hCAFE_F00D, 8'h11);
    reg_ready = 1'b1;
    reg_error = 1'b1;
    tick();
    h.a_valid = 1'b0;
    tick();
    reg_ready = 1'b0;
    reg_error = 1'b0;
    total++;
    if (d.d_valid !== 1'b1 || d.d_opcode !== AccessAck || d.d_error !== 1'b1 || d.d_data !== 32'h0) begin
      bad++; $display("FAIL reg_err_resp: got dv=%b op=%0d err=%b data=%h want 1 0 1 0", d.d_valid, d.d_opcode, d.d_error, d.d_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_a(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'h44);
    reg_ready = 1'b0;
    tick();
    h.a_valid = 1'b0;
    total++;
    if (reg_req !== 1'b1) begin
      bad++; $display("FAIL rst_acc_pre: got req=%b want 1", reg_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (reg_req !== 1'b0 || d.d_valid !== 1'b0 || d.a_ready !== 1'b1) begin
      bad++; $display("FAIL rst_acc_post: got req=%b dv=%b ar=%b want 0 0 1", reg_req, d.d_valid, d.a_ready);
    end
    reg_ready = 1'b1;
    tick();
    tick();
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b0 || reg_req !== 1'b0) begin
      bad++; $display("FAIL rst_acc_noresp: got dv=%b req=%b want 0 0", d.d_valid, reg_req);
    end
    h.d_ready = 1'b0;
    drive_a(3'd4, 2'd2, 32'h34, 4'hF, 32'h0, 8'h45);
    reg_ready = 1'b1;
    tick();
    h.a_valid = 1'b0;
    tick();
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b1) begin
      bad++; $display("FAIL rst_resp_pre: got dv=%b want 1", d.d_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (d.d_valid !== 1'b0 || d.a_ready !== 1'b1 || d.d_data !== 32'h0) begin
      bad++; $display("FAIL rst_resp_post: got dv=%b ar=%b data=%h want 0 1 0", d.d_valid, d.a_ready, d.d_data);
    end
    h.d_ready = 1'b1;
    tick();
  endtask

`ifdef TLUL_PERIPH_REG_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    h.d_ready = 1'b0;
    reg_ready = 1'b0;
    drive_a(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'h50);
    tick();
    h.a_valid = 1'b0;
    n = 0;
    while (reg_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n != 16) begin
      bad++; $display("FAIL tmo_len: got %0d cycles want 16", n);
    end
    total++;
    if (d.d_valid !== 1'b1 || d.d_error !== 1'b1 || d.d_data !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL tmo_resp: got dv=%b err=%b data=%h want 1 1 ffffffff", d.d_valid, d.d_error, d.d_data);
    end
    reg_ready = 1'b1;
    reg_rdata = 32'h0000_1234;
    tick();
    reg_ready = 1'b0;
    total++;
    if (d.d_valid !== 1'b1 || d.d_error !== 1'b1 || d.d_data !== 32'hFFFF_FFFF || reg_req !== 1'b0) begin
      bad++; $display("FAIL tmo_late: got dv=%b err=%b data=%h req=%b", d.d_valid, d.d_error, d.d_data, reg_req);
    end
    h.d_ready = 1'b1;
    tick();
    total++;
    if (d.a_ready !== 1'b1 || d.d_valid !== 1'b0) begin
      bad++; $display("FAIL tmo_idle: got ar=%b dv=%b want 1 0", d.a_ready, d.d_valid);
    end
  endtask
`endif

  initial begin
    h         = '0;
    h.d_ready = 1'b1;
    rst       = 1'b1;
    reg_rdata = 32'h0;
    reg_ready = 1'b0;
    reg_error = 1'b0;
    test_reset();
    test_get();
    test_get_byte();
    test_put_partial();
    test_illegal();
    test_back_to_back();
    test_reg_error();
    test_reset_mid();
`ifdef TLUL_PERIPH_REG_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
